// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM encoding, RAM geometry
// and the wait-counter width helper.
// Ports: none (package).
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam int RAM_DEPTH     = 512;
  localparam int DEF_ADDR_BITS = 9;

  // Width of the wait-state down-counter; never narrower than one bit so that
  // WAIT_STATES=0 still yields a legal vector.
  function automatic int cnt_width(input int wait_states);
    return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that paces the RAM access phase.
// Latency: load/decrement visible the cycle after the edge; zero is combinational from the count.
// Backpressure: none; holds at zero once reached.
// Ports: clk, clear_n (sync active-low), load + load_val, en (decrement), zero (count == 0).
module mem_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: one load/store at a time between CPU MAR/MDR and a combinational-read RAM.
// Latency: request accepted at edge k -> ACCESS cycles k+1..k+1+WAIT_STATES, done pulse in k+2+WAIT_STATES (fault: k+1).
// Backpressure: req is a level sampled only in IDLE; busy is high from the cycle after acceptance through DONE/FAULT.
// Ports: clk, clear_n (sync active-low); CPU side req/wr/addr/wdata -> busy/done/err/rdata;
//        RAM side ram_address/ram_data_in/ram_read/ram_write (all registered) and ram_data_out.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int WAIT_STATES = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              req,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [31:0]       ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int CW = cnt_width(WAIT_STATES);

  state_t            state;
  state_t            state_nxt;

  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;

  logic              accept;
  logic              in_range;
  logic              cnt_zero;

  logic [31:0]       ram_address_nxt;
  logic [DATA_W-1:0] ram_data_in_nxt;
  logic              ram_read_nxt;
  logic              ram_write_nxt;
  logic              capture;

  assign accept   = (state == ST_IDLE) && req;
  assign in_range = ((addr >> ADDR_BITS) == 32'd0);

  mem_wait_counter #(
    .W (CW)
  ) u_wait_cnt (
    .clk      (clk),
    .clear_n  (clear_n),
    .load     (accept && in_range),
    .en       (state == ST_ACCESS),
    .load_val (CW'(WAIT_STATES)),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req) state_nxt = in_range ? ST_ACCESS : ST_FAULT;
      ST_ACCESS: if (cnt_zero) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      ST_FAULT:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. The RAM strobes are computed here one cycle ahead and
  // registered below so the RAM only ever sees flop outputs. On the accepting
  // edge the raw inputs are used since addr_q/wdata_q/wr_q load on that same edge.
  always_comb begin
    ram_address_nxt = '0;
    ram_data_in_nxt = ram_data_in;
    ram_read_nxt    = 1'b0;
    ram_write_nxt   = 1'b0;
    capture         = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && in_range) begin
          ram_address_nxt = addr;
          ram_data_in_nxt = wdata;
          ram_read_nxt    = ~wr;
          ram_write_nxt   = wr;
        end
      end
      ST_ACCESS: begin
        busy = 1'b1;
        if (!cnt_zero) begin
          ram_address_nxt = addr_q;
          ram_data_in_nxt = wdata_q;
          ram_read_nxt    = ~wr_q;
          ram_write_nxt   = wr_q;
        end else begin
          // Last access cycle: RAM data is valid against the still-driven address.
          capture = ~wr_q;
        end
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ST_FAULT: begin
        busy = 1'b1;
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      wr_q    <= wr;
    end
  end

  // Registered RAM interface and MDR-style read register
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      ram_address <= '0;
      ram_data_in <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      rdata       <= '0;
    end else begin
      ram_address <= ram_address_nxt;
      ram_data_in <= ram_data_in_nxt;
      ram_read    <= ram_read_nxt;
      ram_write   <= ram_write_nxt;
      if (capture) begin
        rdata <= ram_data_out;
      end
    end
  end

endmodule
